// File: rtl/mips_pipe_pkg.sv
// Shared pipeline hazard definitions: forwarding select codes, the zero
// register number, and the shadow tag carried per pipeline stage.
package mips_pipe_pkg;

   localparam logic [1:0] FWD_RF   = 2'b00;  // operand from register file
   localparam logic [1:0] FWD_MEM  = 2'b01;  // operand from MEM-stage result
   localparam logic [1:0] FWD_WB   = 2'b10;  // operand from WB-stage result
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Valid is implied by reg_write; a bubble has reg_write=0 and mem_read=0.
   typedef struct packed {
      logic [4:0] dst;
      logic       reg_write;
      logic       mem_read;
   } stage_tag_t;

   localparam stage_tag_t TAG_BUBBLE = '{dst: REG_ZERO, reg_write: 1'b0, mem_read: 1'b0};

   // True when the stage will write the source register (register 0 never matches).
   function automatic logic tag_hit(stage_tag_t tag, logic [4:0] src);
      return tag.reg_write && (tag.dst == src) && (src != REG_ZERO);
   endfunction

endpackage

// File: rtl/hazard_tag_stage.sv
// One pipeline shadow tag register; bubble replaces the incoming tag with an
// empty slot.
module hazard_tag_stage
   import mips_pipe_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       bubble,
   input  stage_tag_t d,
   output stage_tag_t q
);

   stage_tag_t tag_q;

   // Advance the tag each cycle, inserting a bubble when requested.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_q <= TAG_BUBBLE;
      end else if (bubble) begin
         tag_q <= TAG_BUBBLE;
      end else begin
         tag_q <= d;
      end
   end

   assign q = tag_q;

endmodule

// File: rtl/forward_ctrl.sv
// Forwarding and load-use hazard controller for a 5-stage pipeline.
// Build option: define FWD_WB_EN to forward from the WB stage; without it a
// distance-2 dependency stalls one cycle instead.
module forward_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic [4:0]       id_dst,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             flush,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt
);

   stage_tag_t id_tag, ex_tag, mem_tag, wb_tag;
   logic       ex_bubble;
   logic       ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic       load_use, stall_raw;
   logic [1:0] fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
   logic [CNT_W-1:0] cnt_q;

   assign id_tag    = '{dst: id_dst, reg_write: id_reg_write, mem_read: id_mem_read};
   assign ex_bubble = stall | flush;

   hazard_tag_stage u_ex_tag (
      .clk    (clk),
      .rst_n  (rst_n),
      .bubble (ex_bubble),
      .d      (id_tag),
      .q      (ex_tag)
   );

   hazard_tag_stage u_mem_tag (
      .clk    (clk),
      .rst_n  (rst_n),
      .bubble (1'b0),
      .d      (ex_tag),
      .q      (mem_tag)
   );

   hazard_tag_stage u_wb_tag (
      .clk    (clk),
      .rst_n  (rst_n),
      .bubble (1'b0),
      .d      (mem_tag),
      .q      (wb_tag)
   );

   // WB tag only completes the shadow pipeline; nothing downstream reads it.
   logic unused_wb;
   assign unused_wb = ^wb_tag;

   // EX tag now is the producer that will sit in MEM when the ID instruction
   // reaches EX; MEM tag now will sit in WB.
   assign ex_hit_a  = tag_hit(ex_tag, id_rs);
   assign ex_hit_b  = tag_hit(ex_tag, id_rt);
   assign mem_hit_a = tag_hit(mem_tag, id_rs);
   assign mem_hit_b = tag_hit(mem_tag, id_rt);

   // Hazard detection: load-use always stalls; distance-2 stalls without WB forwarding.
   always_comb begin
      load_use = ex_tag.mem_read && (ex_tag.dst != REG_ZERO) &&
                 ((ex_tag.dst == id_rs) || (ex_tag.dst == id_rt));
`ifdef FWD_WB_EN
      stall_raw = load_use;
`else
      // A newer EX producer of the same register supersedes the MEM one.
      stall_raw = load_use || (mem_hit_a && !ex_hit_a) || (mem_hit_b && !ex_hit_b);
`endif
      stall = stall_raw && !flush;
   end

   // Next forwarding selects; newest producer wins, bubbles get the register file.
   always_comb begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
      if (ex_hit_a) begin
         fwd_a_d = FWD_MEM;
      end
`ifdef FWD_WB_EN
      else if (mem_hit_a) begin
         fwd_a_d = FWD_WB;
      end
`endif
      if (ex_hit_b) begin
         fwd_b_d = FWD_MEM;
      end
`ifdef FWD_WB_EN
      else if (mem_hit_b) begin
         fwd_b_d = FWD_WB;
      end
`endif
      if (ex_bubble) begin
         fwd_a_d = FWD_RF;
         fwd_b_d = FWD_RF;
      end
   end

   // Register the selects so they are valid while the instruction is in EX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a_q <= FWD_RF;
         fwd_b_q <= FWD_RF;
      end else begin
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
      end
   end

   // Saturating count of stall cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign fwd_a_sel = fwd_a_q;
   assign fwd_b_sel = fwd_b_q;
   assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_ctrl.sv
// Table-driven bench for forward_ctrl, plus hand sequences for reset during a
// stall and counter saturation. Expectations follow FWD_WB_EN if defined.
module tb_forward_ctrl;

   localparam int unsigned CNT_W = 4;
`ifdef FWD_WB_EN
   localparam int NM = 0;
`else
   localparam int NM = 1;
`endif
   localparam int CF = 1 + 2 * NM;  // stall count after the REQ-030 segment

   logic             clk;
   logic             rst_n;
   logic [4:0]       id_rs, id_rt, id_dst;
   logic             id_reg_write, id_mem_read, flush;
   logic [1:0]       fwd_a_sel, fwd_b_sel;
   logic             stall;
   logic [CNT_W-1:0] stall_cnt;

   int checks;
   int failures;

   forward_ctrl #(.CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_dst       (id_dst),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .flush        (flush),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .stall        (stall),
      .stall_cnt    (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [4:0]  rs, rt, dst;
      logic        rw, mr, fl;
      logic        exp_stall;
      logic [1:0]  exp_a, exp_b;
      logic [31:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic void mk(string n, int rs, int rt, int dst, int rw, int mr, int fl,
                              int st, int a, int b, int cnt);
      vec_t v;
      v.name = n;
      v.rs = 5'(rs);  v.rt = 5'(rt);  v.dst = 5'(dst);
      v.rw = 1'(rw);  v.mr = 1'(mr);  v.fl = 1'(fl);
      v.exp_stall = 1'(st);
      v.exp_a = 2'(a);  v.exp_b = 2'(b);
      v.exp_cnt = 32'(cnt);
      vecs.push_back(v);
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(int rs, int rt, int dst, int rw, int mr, int fl);
      id_rs = 5'(rs);  id_rt = 5'(rt);  id_dst = 5'(dst);
      id_reg_write = 1'(rw);  id_mem_read = 1'(mr);  flush = 1'(fl);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nstall;
      checks   = 0;
      failures = 0;

      //  name         rs rt dst rw mr fl | stall a  b  cnt
      mk("r0_add3",    1, 2, 3,  1, 0, 0,   0,    0, 0, 0);
      mk("r1_fwd_mem", 3, 1, 4,  1, 0, 0,   0,    1, 0, 0);
      mk("r2_nop",     0, 0, 0,  0, 0, 0,   0,    0, 0, 0);
      mk("r3_add3",    1, 2, 3,  1, 0, 0,   0,    0, 0, 0);
      mk("r4_nop",     0, 0, 0,  0, 0, 0,   0,    0, 0, 0);
`ifdef FWD_WB_EN
      mk("r5_fwd_wb",  2, 3, 5,  1, 0, 0,   0,    0, 2, 0);
`else
      mk("r5_d2stall", 2, 3, 5,  1, 0, 0,   1,    0, 0, 1);
      mk("r5_after",   2, 3, 5,  1, 0, 0,   0,    0, 0, 1);
`endif
      mk("r6_lw7",     1, 0, 7,  1, 1, 0,   0,    0, 0, NM);
      mk("r7_ldstall", 7, 7, 8,  1, 0, 0,   1,    0, 0, NM + 1);
`ifdef FWD_WB_EN
      mk("r8_ld_wb",   7, 7, 8,  1, 0, 0,   0,    2, 2, 1);
`else
      mk("r8_d2stall", 7, 7, 8,  1, 0, 0,   1,    0, 0, 3);
      mk("r8_after",   7, 7, 8,  1, 0, 0,   0,    0, 0, 3);
`endif
      mk("r9_dst0",    1, 2, 0,  1, 0, 0,   0,    0, 0, CF);
      mk("r10_src0",   0, 0, 4,  1, 0, 0,   0,    0, 0, CF);
      mk("r11_lw7",    0, 0, 7,  1, 1, 0,   0,    0, 0, CF);
      mk("r12_flush",  7, 7, 8,  1, 0, 1,   0,    0, 0, CF);
      mk("r13_postfl", 1, 2, 9,  1, 0, 0,   0,    0, 0, CF);
      mk("r14_add6",   1, 2, 6,  1, 0, 0,   0,    0, 0, CF);
      mk("r15_add6",   3, 4, 6,  1, 0, 0,   0,    0, 0, CF);
      mk("r16_newest", 6, 6, 10, 1, 0, 0,   0,    1, 1, CF);

      // Reset state
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_sel_a", 32'(fwd_a_sel), 32'd0);
      check("rst_sel_b", 32'(fwd_b_sel), 32'd0);
      check("rst_cnt", 32'(stall_cnt), 32'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(int'(vecs[i].rs), int'(vecs[i].rt), int'(vecs[i].dst),
               int'(vecs[i].rw), int'(vecs[i].mr), int'(vecs[i].fl));
         #1;
         check({vecs[i].name, "_stall"}, 32'(stall), 32'(vecs[i].exp_stall));
         @(posedge clk);
         #1;
         check({vecs[i].name, "_sel_a"}, 32'(fwd_a_sel), 32'(vecs[i].exp_a));
         check({vecs[i].name, "_sel_b"}, 32'(fwd_b_sel), 32'(vecs[i].exp_b));
         check({vecs[i].name, "_cnt"}, 32'(stall_cnt), vecs[i].exp_cnt);
      end

      // Reset asserted in the middle of a load-use stall
      drive(10, 0, 7, 1, 1, 0);  // lw $7,0($10): $10 forwarded from MEM
      @(posedge clk);
      #1;
      check("mid_lw_sel_a", 32'(fwd_a_sel), 32'd1);
      drive(7, 7, 8, 1, 0, 0);
      #1;
      check("mid_stall_pre", 32'(stall), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_stall", 32'(stall), 32'd0);
      check("mid_rst_sel_a", 32'(fwd_a_sel), 32'd0);
      check("mid_rst_cnt", 32'(stall_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post_rst_stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      check("post_rst_sel_a", 32'(fwd_a_sel), 32'd0);
      check("post_rst_sel_b", 32'(fwd_b_sel), 32'd0);
      check("post_rst_cnt", 32'(stall_cnt), 32'd0);

      // Saturation: lw $7,0($7) back to back keeps producing load-use stalls
      drive(7, 0, 7, 1, 1, 0);
      nstall = 0;
      for (int cyc = 0; cyc < 200 && nstall < 19; cyc++) begin
         logic s;
         s = stall;
         if (s) nstall++;
         @(posedge clk);
         #1;
         if (s && (nstall == 1 || nstall == 15 || nstall == 16 || nstall == 19)) begin
            check($sformatf("sat_cnt_%0d", nstall), 32'(stall_cnt),
                  (nstall >= 15) ? 32'd15 : 32'(nstall));
         end
      end
      check("sat_stall_budget", 32'(nstall), 32'd19);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
